// File: rtl/matrix_stream_io.sv
// Serial element stream <-> parallel 2x2 matrix multiplier adapter.
// Loads A then B element by element, starts the multiplier, and streams the product back out.
module matrix_stream_io #(
  parameter int ELEM_W  = 3,
  parameter int RES_W   = 6,
  parameter int TIMEOUT = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ELEM_W-1:0]   in_elem,
  output logic [4*ELEM_W-1:0] matrix_A,
  output logic [4*ELEM_W-1:0] matrix_B,
  output logic                mm_start,
  input  logic                mm_done,
  input  logic [4*RES_W-1:0]  mm_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RES_W-1:0]    out_elem,
  output logic [1:0]          out_index,
  output logic                out_last,
  output logic                err
);

  localparam logic [2:0] LOAD_A = 3'd0;
  localparam logic [2:0] LOAD_B = 3'd1;
  localparam logic [2:0] START  = 3'd2;
  localparam logic [2:0] WAIT   = 3'd3;
  localparam logic [2:0] SEND   = 3'd4;

  localparam int WC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(TIMEOUT - 1);

  logic [2:0]                state;
  logic [1:0]                cnt;
  logic [WC_W-1:0]           wcnt;
  logic [3:0][ELEM_W-1:0]    a_q;
  logic [3:0][ELEM_W-1:0]    b_q;
  logic [3:0][RES_W-1:0]     res_q;

  assign matrix_A = a_q;
  assign matrix_B = b_q;

  // Handshake outputs are forced low while reset is held, not just after the edge.
  always_comb begin
    in_ready  = !reset && (state == LOAD_A || state == LOAD_B);
    mm_start  = !reset && (state == START);
    out_valid = !reset && (state == SEND);
    out_index = out_valid ? cnt : 2'd0;
    out_elem  = out_valid ? res_q[cnt] : '0;
    out_last  = out_valid && (cnt == 2'd3);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= LOAD_A;
      cnt   <= 2'd0;
      wcnt  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        LOAD_A: if (in_valid) begin
          a_q[cnt] <= in_elem;
          if (cnt == 2'd0) err <= 1'b0;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) state <= LOAD_B;
        end
        LOAD_B: if (in_valid) begin
          b_q[cnt] <= in_elem;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) state <= START;
        end
        START: begin
          wcnt  <= '0;
          state <= WAIT;
        end
        // A late mm_done on the timeout cycle still counts as success.
        WAIT: if (mm_done) begin
          res_q <= mm_result;
          err   <= 1'b0;
          state <= SEND;
        end else if (wcnt == WC_MAX) begin
          res_q <= '0;
          err   <= 1'b1;
          state <= SEND;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
        SEND: if (out_ready) begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) state <= LOAD_A;
        end
        default: state <= LOAD_A;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_stream_io.sv
// Directed bench for matrix_stream_io: load/start/wait/send, backpressure, timeout, reset abort.
module tb_matrix_stream_io;
  localparam int TO = 8;

  logic        clock = 1'b0;
  logic        reset, in_valid, in_ready, mm_start, mm_done;
  logic        out_valid, out_ready, out_last, err;
  logic [2:0]  in_elem;
  logic [11:0] matrix_A, matrix_B;
  logic [23:0] mm_result;
  logic [5:0]  out_elem;
  logic [1:0]  out_index;

  int checks = 0;
  int errors = 0;
  int n_out = 0;
  int n_start = 0;

  matrix_stream_io #(.ELEM_W(3), .RES_W(6), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_elem(in_elem), .matrix_A(matrix_A), .matrix_B(matrix_B),
    .mm_start(mm_start), .mm_done(mm_done), .mm_result(mm_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_elem(out_elem),
    .out_index(out_index), .out_last(out_last), .err(err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (out_valid && out_ready) n_out++;
    if (mm_start) n_start++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bound_fail(input string tag);
    checks++;
    errors++;
    $display("FAIL %s: observed timeout expected handshake", tag);
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic push(input logic [2:0] v);
    int n = 0;
    in_valid = 1'b1;
    in_elem  = v;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) bound_fail("push_wait");
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic recv(input int idx, input logic [5:0] val);
    int n = 0;
    out_ready = 1'b1;
    while (!out_valid && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) bound_fail("recv_wait");
    chk($sformatf("elem%0d", idx), 32'(out_elem), 32'(val));
    chk($sformatf("index%0d", idx), 32'(out_index), 32'(idx));
    chk($sformatf("last%0d", idx), 32'(out_last), 32'(idx == 3));
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    logic [2:0] vals [8];
    vals = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    reset = 1'b1; in_valid = 1'b0; in_elem = '0;
    mm_done = 1'b0; mm_result = '0; out_ready = 1'b0;

    // Reset state
    @(negedge clock); @(negedge clock);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_mm_start", 32'(mm_start), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_elem", 32'(out_elem), 0);
    chk("rst_matrix_A", 32'(matrix_A), 0);
    chk("rst_err", 32'(err), 0);
    reset = 1'b0;
    #1 chk("post_rst_in_ready", 32'(in_ready), 1);

    // 1: back-to-back load and packing
    for (int i = 0; i < 8; i++) push(vals[i]);
    chk("t1_mm_start", 32'(mm_start), 1);
    chk("t1_matrix_A", 32'(matrix_A), 32'h8D1);
    chk("t1_matrix_B", 32'(matrix_B), 32'({3'd0, 3'd7, 3'd6, 3'd5}));
    chk("t1_in_ready", 32'(in_ready), 0);

    // 2: mm_done in the third cycle after start
    mm_result = 24'h0C4083;
    @(negedge clock);
    chk("t1_start_one_cycle", 32'(mm_start), 0);
    chk("t2_wait_valid", 32'(out_valid), 0);
    @(negedge clock);
    @(negedge clock);
    mm_done = 1'b1;
    @(negedge clock);
    mm_done = 1'b0;
    chk("t2_latency", 32'(out_valid), 1);
    chk("t2_A_stable", 32'(matrix_A), 32'h8D1);
    out_ready = 1'b1;
    recv(0, 6'd3); recv(1, 6'd2); recv(2, 6'd4); recv(3, 6'd3);
    chk("t2_in_ready", 32'(in_ready), 1);
    chk("t2_out_valid", 32'(out_valid), 0);
    chk("t2_err", 32'(err), 0);

    // 3: backpressure during index 1
    for (int i = 0; i < 8; i++) push(3'(i + 2));
    mm_result = {6'd40, 6'd33, 6'd17, 6'd9};
    @(negedge clock);
    mm_done = 1'b1;
    @(negedge clock);
    mm_done = 1'b0;
    recv(0, 6'd9);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", 32'(out_valid), 1);
      chk("t3_hold_elem", 32'(out_elem), 32'd17);
      chk("t3_hold_index", 32'(out_index), 1);
      @(negedge clock);
    end
    recv(1, 6'd17); recv(2, 6'd33); recv(3, 6'd40);

    // 4: timeout abort
    for (int i = 0; i < 8; i++) push(3'd7);
    chk("t4_mm_start", 32'(mm_start), 1);
    mm_result = 24'hABCDEF;
    for (int i = 0; i < TO; i++) begin
      @(negedge clock);
      chk("t4_wait_valid", 32'(out_valid), 0);
    end
    @(negedge clock);
    chk("t4_timeout_valid", 32'(out_valid), 1);
    chk("t4_err_set", 32'(err), 1);
    recv(0, 6'd0); recv(1, 6'd0); recv(2, 6'd0); recv(3, 6'd0);
    chk("t4_err_sticky", 32'(err), 1);
    push(3'd5);
    chk("t4_err_clear", 32'(err), 0);
    chk("t4_A0", 32'(matrix_A[2:0]), 32'd5);

    // 5: reset in the middle of loading B
    push(3'd1); push(3'd1); push(3'd1);
    push(3'd6); push(3'd6);
    reset = 1'b1;
    #1 chk("t5_rst_in_ready", 32'(in_ready), 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("t5_A_cleared", 32'(matrix_A), 0);
    chk("t5_B_cleared", 32'(matrix_B), 0);
    chk("t5_in_ready", 32'(in_ready), 1);
    push(3'd3);
    chk("t5_A0_landed", 32'(matrix_A), 32'd3);
    chk("t5_no_start", 32'(mm_start), 0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;

    // 6: gapped input, spurious mm_done during loading
    mm_done = 1'b1;
    mm_result = 24'hFFFFFF;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) mm_done = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        @(negedge clock);
        chk("t6_gap_valid", 32'(out_valid), 0);
        chk("t6_gap_start", 32'(mm_start), 0);
      end
      push(vals[i]);
    end
    chk("t6_mm_start", 32'(mm_start), 1);
    chk("t6_matrix_A", 32'(matrix_A), 32'h8D1);
    chk("t6_matrix_B", 32'(matrix_B), 32'h1F5);
    mm_result = 24'h0C4083;
    @(negedge clock);
    mm_done = 1'b1;
    @(negedge clock);
    mm_done = 1'b0;
    recv(0, 6'd3); recv(1, 6'd2); recv(2, 6'd4); recv(3, 6'd3);
    chk("t6_in_ready", 32'(in_ready), 1);

    @(negedge clock);
    chk("total_out_xfers", 32'(n_out), 32'd16);
    chk("total_starts", 32'(n_start), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
